// File: rtl/arbitro_rr_decod_4.sv
// Round-robin arbiter for four requesters sharing one resource.
// The winner is held as a 2-bit code and expanded to a one-hot grant by a 2x4 decoder.
module arbitro_rr_decod_4 #(
   parameter int unsigned MAX_HOLD = 8,
   parameter int unsigned CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       req,
   output logic [3:0]       gnt,
   output logic [1:0]       gnt_idx,
   output logic             gnt_valid,
   output logic [CNT_W-1:0] hold_cnt,
   output logic [1:0]       dbg_state,
   output logic [1:0]       dbg_ptr
);

   typedef enum logic [1:0] {
      OCIOSO  = 2'd0,
      CONCEDE = 2'd1,
      LIBERA  = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

   // Decoder: A is the index MSB, B the LSB; Y0..Y3 one-hot.
   function automatic logic [3:0] decod_2x4(input logic a, input logic b);
      logic [3:0] y;
      y[0] = ~a & ~b;
      y[1] = ~a &  b;
      y[2] =  a & ~b;
      y[3] =  a &  b;
      return y;
   endfunction

   // First requester found scanning ptr, ptr+1, ... modulo 4.
   function automatic logic [1:0] sel_rr(input logic [1:0] ptr, input logic [3:0] r);
      logic [1:0] idx;
      logic [1:0] res;
      logic       found;
      res   = ptr;
      found = 1'b0;
      for (int k = 0; k < 4; k++) begin
         idx = ptr + 2'(k);
         if (!found && r[idx]) begin
            res   = idx;
            found = 1'b1;
         end
      end
      return res;
   endfunction

   state_t           state_q, state_d;
   logic [1:0]       ptr_q, ptr_d;
   logic [1:0]       gnt_idx_q, gnt_idx_d;
   logic             gnt_valid_q, gnt_valid_d;
   logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
   logic [3:0]       gnt_q, gnt_d;

   logic       req_any;
   logic       start_grant;
   logic [1:0] sel_idx;
   logic       owner_drop;
   logic       others_wait;
   logic       release_c;

   assign req_any     = |req;
   assign start_grant = en && req_any;
   assign sel_idx     = sel_rr(ptr_q, req);
   assign owner_drop  = !req[gnt_idx_q];
   assign others_wait = |(req & ~gnt_q);
   // Preemption only once the hold budget is spent and someone else is waiting.
   assign release_c   = owner_drop || ((hold_cnt_q == HOLD_LAST) && others_wait);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= OCIOSO;
         ptr_q       <= 2'b00;
         gnt_idx_q   <= 2'b00;
         gnt_valid_q <= 1'b0;
         hold_cnt_q  <= '0;
         gnt_q       <= 4'b0000;
      end else begin
         state_q     <= state_d;
         ptr_q       <= ptr_d;
         gnt_idx_q   <= gnt_idx_d;
         gnt_valid_q <= gnt_valid_d;
         hold_cnt_q  <= hold_cnt_d;
         gnt_q       <= gnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         OCIOSO:  if (start_grant) state_d = CONCEDE;
         CONCEDE: if (release_c)   state_d = LIBERA;
         LIBERA:  state_d = start_grant ? CONCEDE : OCIOSO;
         default: state_d = OCIOSO;
      endcase
   end

   always_comb begin
      ptr_d       = ptr_q;
      gnt_idx_d   = gnt_idx_q;
      gnt_valid_d = gnt_valid_q;
      hold_cnt_d  = hold_cnt_q;
      unique case (state_q)
         OCIOSO, LIBERA: begin
            if (start_grant) begin
               gnt_idx_d   = sel_idx;
               gnt_valid_d = 1'b1;
               hold_cnt_d  = '0;
            end else begin
               gnt_valid_d = 1'b0;
            end
         end
         CONCEDE: begin
            if (release_c) begin
               gnt_valid_d = 1'b0;
               ptr_d       = gnt_idx_q + 2'd1;
               hold_cnt_d  = '0;
            end else if (hold_cnt_q != HOLD_LAST) begin
               hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end
         end
         default: begin
            gnt_valid_d = 1'b0;
         end
      endcase
      gnt_d = decod_2x4(gnt_idx_d[1], gnt_idx_d[0]) & {4{gnt_valid_d}};
   end

   assign gnt       = gnt_q;
   assign gnt_idx   = gnt_idx_q;
   assign gnt_valid = gnt_valid_q;
   assign hold_cnt  = hold_cnt_q;
   assign dbg_state = state_q;
   assign dbg_ptr   = ptr_q;

endmodule
